// File: rtl/aes_key_sched_ctrl.sv
// rtl/aes_key_sched_ctrl.sv - AES-128 key-expansion sequencer with an 11-entry round-key store
// Drives an external one-round expansion step and serves round keys through a registered read port.
module aes_key_sched_ctrl #(
   parameter int WIDTH  = 32,
   parameter int NROUND = 10
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 key_valid,
   output logic                 key_ready,
   input  logic [4*WIDTH-1:0]   key_in,
   input  logic                 key_clear,
   output logic [4*WIDTH-1:0]   step_w_o,
   output logic [3:0]           step_cnt_o,
   input  logic [4*WIDTH-1:0]   step_w_i,
   input  logic [3:0]           rk_addr,
   output logic [4*WIDTH-1:0]   rk_data,
   output logic                 keys_valid,
   output logic                 busy
);
   localparam int         KW   = 4 * WIDTH;
   localparam logic [3:0] LAST = 4'(NROUND);

   typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

   state_t        state;
   state_t        state_next;
   logic [3:0]    cnt;
   logic [3:0]    cnt_prev;
   logic [KW-1:0] store [0:NROUND];
   logic          accept;

   // key_clear wins over a simultaneous handshake, so it vetoes acceptance here
   assign accept   = key_valid && (state != EXPAND) && !key_clear;
   assign cnt_prev = cnt - 4'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      key_ready  = 1'b0;
      busy       = 1'b0;
      keys_valid = 1'b0;
      step_w_o   = '0;
      step_cnt_o = '0;
      case (state)
         IDLE: begin
            key_ready = 1'b1;
            if (accept) state_next = EXPAND;
         end
         EXPAND: begin
            busy       = 1'b1;
            step_cnt_o = cnt;
            if (cnt_prev <= LAST) step_w_o = store[cnt_prev];
            if (cnt == LAST) state_next = READY;
         end
         READY: begin
            key_ready  = 1'b1;
            keys_valid = 1'b1;
            if (accept) state_next = EXPAND;
         end
         default: state_next = IDLE;
      endcase
      if (key_clear) state_next = IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i <= NROUND; i++) store[i] <= '0;
         cnt     <= '0;
         rk_data <= '0;
      end else if (key_clear) begin
         for (int i = 0; i <= NROUND; i++) store[i] <= '0;
         cnt     <= '0;
         rk_data <= '0;
      end else begin
         if (accept) begin
            store[0] <= key_in;
            cnt      <= 4'd1;
         end else if (state == EXPAND) begin
            if (cnt <= LAST) store[cnt] <= step_w_i;
            cnt <= (cnt == LAST) ? 4'd0 : cnt + 4'd1;
         end
         // Reads return zero unless the store is complete and stays so past this edge
         if ((state == READY) && !accept && (rk_addr <= LAST)) begin
            rk_data <= store[rk_addr];
         end else begin
            rk_data <= '0;
         end
      end
   end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// tb/tb_aes_key_sched_ctrl.sv - directed bench for aes_key_sched_ctrl with a behavioural expansion step
module tb_aes_key_sched_ctrl;
   logic         clk = 1'b0;
   logic         rst_n;
   logic         key_valid;
   logic         key_ready;
   logic [127:0] key_in;
   logic         key_clear;
   logic [127:0] step_w_o;
   logic [3:0]   step_cnt_o;
   logic [127:0] step_w_i;
   logic [3:0]   rk_addr;
   logic [127:0] rk_data;
   logic         keys_valid;
   logic         busy;

   int checks = 0;
   int errors = 0;

   localparam logic [127:0] K1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] K2   = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] K1R1 = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] K1RA = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] K2R1 = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
   localparam logic [127:0] K2RA = 128'h13111d7fe3944a17f307a78b4d2b30c5;

   logic [127:0] exp1 [0:10];
   logic [127:0] exp2 [0:10];

   aes_key_sched_ctrl dut (
      .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_ready(key_ready),
      .key_in(key_in), .key_clear(key_clear), .step_w_o(step_w_o),
      .step_cnt_o(step_cnt_o), .step_w_i(step_w_i), .rk_addr(rk_addr),
      .rk_data(rk_data), .keys_valid(keys_valid), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [2047:0] t;
      t = {128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
           128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
           128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
           128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
           128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
           128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
           128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
           128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
      return t[2047 - 8*int'(x) -: 8];
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] r);
      case (r)
         4'd1: return 8'h01;   4'd2: return 8'h02;   4'd3: return 8'h04;
         4'd4: return 8'h08;   4'd5: return 8'h10;   4'd6: return 8'h20;
         4'd7: return 8'h40;   4'd8: return 8'h80;   4'd9: return 8'h1b;
         4'd10: return 8'h36;  default: return 8'h00;
      endcase
   endfunction

   function automatic logic [127:0] step_fn(input logic [127:0] w, input logic [3:0] r);
      logic [31:0] rot, tmp, n0, n1, n2, n3;
      rot = {w[23:0], w[31:24]};
      tmp = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])} ^ {rcon(r), 24'h0};
      n0  = w[127:96] ^ tmp;
      n1  = w[95:64] ^ n0;
      n2  = w[63:32] ^ n1;
      n3  = w[31:0] ^ n2;
      return {n0, n1, n2, n3};
   endfunction

   assign step_w_i = step_fn(step_w_o, step_cnt_o);

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n = 1'b0; key_valid = 1'b0; key_in = '0; key_clear = 1'b0; rk_addr = '0;
      exp1[0] = K1;
      exp2[0] = K2;
      for (int r = 1; r <= 10; r++) begin
         exp1[r] = step_fn(exp1[r-1], 4'(r));
         exp2[r] = step_fn(exp2[r-1], 4'(r));
      end
      chk("model_k1_r1", exp1[1], K1R1);
      chk("model_k1_r10", exp1[10], K1RA);
      chk("model_k2_r1", exp2[1], K2R1);
      chk("model_k2_r10", exp2[10], K2RA);

      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_key_ready", key_ready, 1);
      chk("rst_keys_valid", keys_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rk_data", rk_data, 0);
      chk("rst_step_w", step_w_o, 0);
      chk("rst_step_cnt", step_cnt_o, 0);

      // FIPS-197 key; key_valid stays high with other data during expansion
      key_valid = 1'b1; key_in = K1;
      @(negedge clk);
      key_in = K2;
      for (int i = 1; i <= 10; i++) begin
         chk($sformatf("exp_busy_%0d", i), busy, 1);
         chk($sformatf("exp_ready_%0d", i), key_ready, 0);
         chk($sformatf("exp_kv_%0d", i), keys_valid, 0);
         chk($sformatf("exp_cnt_%0d", i), step_cnt_o, 128'(i));
         chk($sformatf("exp_w_%0d", i), step_w_o, exp1[i-1]);
         if (i == 10) key_valid = 1'b0;
         @(negedge clk);
      end
      chk("done_kv", keys_valid, 1);
      chk("done_busy", busy, 0);
      chk("done_ready", key_ready, 1);
      chk("done_step_w", step_w_o, 0);
      chk("done_step_cnt", step_cnt_o, 0);
      for (int a = 0; a <= 15; a++) begin
         rk_addr = 4'(a);
         @(negedge clk);
         chk($sformatf("rk1_%0d", a), rk_data, (a <= 10) ? exp1[a] : 128'h0);
      end
      rk_addr = 4'd0;  @(negedge clk); chk("rk1_fips_0", rk_data, K1);
      rk_addr = 4'd1;  @(negedge clk); chk("rk1_fips_1", rk_data, K1R1);
      rk_addr = 4'd10; @(negedge clk); chk("rk1_fips_10", rk_data, K1RA);

      // Rekey from READY
      key_valid = 1'b1; key_in = K2;
      @(negedge clk);
      key_valid = 1'b0;
      chk("rekey_kv_drop", keys_valid, 0);
      chk("rekey_busy", busy, 1);
      for (int j = 1; j <= 10; j++) begin
         chk($sformatf("rekey_rd_zero_%0d", j), rk_data, 0);
         chk($sformatf("rekey_kv_%0d", j), keys_valid, 0);
         @(negedge clk);
      end
      chk("rekey_kv_done", keys_valid, 1);
      @(negedge clk);
      chk("rekey_rk10", rk_data, K2RA);
      rk_addr = 4'd1; @(negedge clk); chk("rekey_rk1", rk_data, K2R1);

      // key_clear at EXPAND cycle 5 together with a key offer
      key_valid = 1'b1; key_in = K1;
      @(negedge clk);
      key_valid = 1'b0;
      repeat (4) @(negedge clk);
      chk("clr_at_cnt5", step_cnt_o, 5);
      chk("clr_at_w", step_w_o, exp1[4]);
      key_clear = 1'b1; key_valid = 1'b1; key_in = K2;
      @(negedge clk);
      key_clear = 1'b0; key_valid = 1'b0;
      chk("clr_ready", key_ready, 1);
      chk("clr_kv", keys_valid, 0);
      chk("clr_busy", busy, 0);
      chk("clr_cnt", step_cnt_o, 0);
      for (int a = 0; a <= 10; a++) begin
         rk_addr = 4'(a);
         @(negedge clk);
         chk($sformatf("clr_rd_%0d", a), rk_data, 0);
         chk($sformatf("clr_idle_%0d", a), busy, 0);
      end

      // Asynchronous reset between edges mid-expansion
      key_valid = 1'b1; key_in = K1;
      @(negedge clk);
      key_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("ar_pre_busy", busy, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_busy", busy, 0);
      chk("ar_kv", keys_valid, 0);
      chk("ar_step_w", step_w_o, 0);
      chk("ar_step_cnt", step_cnt_o, 0);
      chk("ar_rk_data", rk_data, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("ar_rel_ready", key_ready, 1);
      chk("ar_rel_kv", keys_valid, 0);
      chk("ar_rel_busy", busy, 0);

      // Full run after reset recovers the K1 schedule
      key_valid = 1'b1; key_in = K1;
      @(negedge clk);
      key_valid = 1'b0;
      repeat (10) @(negedge clk);
      chk("post_kv", keys_valid, 1);
      rk_addr = 4'd10; @(negedge clk); chk("post_rk10", rk_data, K1RA);
      rk_addr = 4'd5;  @(negedge clk); chk("post_rk5", rk_data, exp1[5]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/aes_key_sched_ctrl.md
Name: aes_key_sched_ctrl

Overview:
Sequencer for the one-round AES-128 key-expansion step. It accepts a 128-bit cipher key through a valid/ready handshake. It then drives the step for 10 rounds, one round per clock, and stores all 11 round keys in an internal key store. The cipher round datapath reads round keys through a registered read port once keys_valid is asserted.

Parameters:
WIDTH, 32, word width; a round key is 4*WIDTH bits. Only 32 is supported.
NROUND, 10, number of generated round keys. Only 10 (AES-128) is supported.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
key_valid  input  1  cipher key offered
key_ready  output  1  controller can accept a key
key_in  input  128  cipher key; W0 = [127:96], W3 = [31:0]
key_clear  input  1  synchronous abort/zeroise
step_w_o  output  128  {W0,W1,W2,W3} driven to the expansion step
step_cnt_o  output  4  round index driven to the expansion step (1..10)
step_w_i  input  128  {W0',W1',W2',W3'} returned combinationally by the step
rk_addr  input  4  round-key index, 0..10
rk_data  output  128  round key at rk_addr, 1-cycle latency
keys_valid  output  1  all 11 round keys are stored and stable
busy  output  1  expansion in progress

Behaviour:
- Reset (rst_n low, asynchronous) forces all of the following, independent of clk:
  - state to IDLE;
  - key store (11 x 128) to zero;
  - round counter to 0;
  - keys_valid, busy and rk_data to 0;
  - key_ready to 1 after release.
- FSM states: IDLE, EXPAND, READY.
  - IDLE: key_ready=1. On key_valid&key_ready, write key_in to slot 0, set cnt=1, go to EXPAND.
  - EXPAND: key_ready=0, busy=1. step_w_o = slot[cnt-1] and step_cnt_o = cnt; both are registered-source, combinational from state. Each cycle, capture step_w_i into slot[cnt] and increment cnt. The capture with cnt=10 moves the FSM to READY and sets keys_valid=1 on that same edge.
  - READY: key_ready=1, keys_valid=1, busy=0. A new key handshake loads slot 0, clears keys_valid on the same edge, and returns to EXPAND (rekey). Slots 1..10 keep their old values until overwritten.
- Latency: handshake accepted at edge T gives keys_valid=1 after edge T+10. Exactly 10 EXPAND cycles.
- step_w_o and step_cnt_o are 0 outside EXPAND.
- The key store is written only by a slot-0 load or an EXPAND capture.
- Read port:
  - rk_data is registered every cycle from slot[rk_addr].
  - rk_addr > 10 yields 0.
  - While keys_valid=0, rk_data = 0 regardless of address.
- key_clear, sampled at the clock edge, in any state:
  - zeroise the whole store, rk_data and cnt;
  - go to IDLE with keys_valid=0.
  - key_clear has priority over a simultaneous key handshake; the key is not accepted.
- key_valid during EXPAND is ignored (key_ready=0); the offered key must be held by the source.
- Reset mid-EXPAND gives a full reset; no partial keys remain.
- keys_valid, busy and key_ready are registered or derived from state only; there is no combinational path from key_valid.
- No width growth; all arithmetic is XOR inside the step. cnt is 4 bits and never exceeds 10.

Test Plan:
1. FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c accepted at edge T -> busy high for 10 cycles, keys_valid=1 after edge T+10. rk_addr=0 reads 2b7e151628aed2a6abf7158809cf4f3c, 1 reads a0fafe1788542cb123a339392a6c7605, 10 reads d014f9a8c9ee2589e13f0cc8b6630ca6.
2. Step port monitor during scenario 1 -> step_cnt_o sequences 1,2,...,10 on consecutive cycles. step_w_o equals the previous round key each cycle, and is 0 before and after.
3. Rekey in READY with key 000102030405060708090a0b0c0d0e0f -> keys_valid drops on the accept edge. After 10 cycles, rk_addr=10 reads 13111d7fe3944a17f307a78b4d2b30c5 and rk_data reads 0 during expansion.
4. key_clear asserted at EXPAND cycle 5, together with key_valid=1 -> next cycle IDLE, key_ready=1, keys_valid=0, all addresses 0..10 read 0, and the key is not accepted.
5. rst_n pulsed low mid-EXPAND, between clock edges -> outputs zero immediately; after release, IDLE with key_ready=1 and keys_valid=0.
6. rk_addr=11..15 in READY -> rk_data=0. key_valid held high during EXPAND -> no reload, and the final keys match scenario 1.
